audio_frame_ctrl: RTL and testbench



---
 rtl/audio_pkg.sv | 18 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/audio_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_audio_frame_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types for the audio framing path: word width, framer states and the
// stereo frame layout carried through the frame FIFO.
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_L = 2'd1,
        WAIT_R = 2'd2
    } state_e;

    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] left;
        logic [AUDIO_DATA_W-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush. A push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/audio_frame_ctrl.sv
// Pairs SPI words into left/right frames, buffers them, and releases one frame
// per sample_tick over valid/ready while tracking overflow, underflow and resync.
module audio_frame_ctrl
    import audio_pkg::*;
#(
    parameter int DATA_W     = AUDIO_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sel,
    input  logic [DATA_W-1:0]             word_in,
    input  logic                          word_valid,
    input  logic                          sample_tick,
    output logic [DATA_W-1:0]             out_left,
    output logic [DATA_W-1:0]             out_right,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              overflow_cnt,
    output logic [CNT_W-1:0]              underflow_cnt,
    output logic                          frame_err
);

    localparam int FRAME_W = 2 * DATA_W;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   left_q, left_d;
    logic                sel_q;
    logic [DATA_W-1:0]   out_left_q, out_left_d;
    logic [DATA_W-1:0]   out_right_q, out_right_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [CNT_W-1:0]    ovf_q, ovf_d;
    logic [CNT_W-1:0]    unf_q, unf_d;

    logic                sel_rise;
    logic                stage_free;
    logic                push, pop;
    logic                fifo_full, fifo_empty;
    logic [FRAME_W-1:0]  fifo_rdata;

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (!enable),
        .push  (push),
        .pop   (pop),
        .wdata ({left_q, word_in}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A word arriving together with the chip-select rise still completes the frame.
    assign sel_rise   = sel && !sel_q;
    assign stage_free = !out_valid_q || out_ready;
    assign push       = enable && (state_q == WAIT_R) && word_valid;
    assign pop        = enable && sample_tick && !fifo_empty && stage_free;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_L;
            end
            WAIT_L: begin
                if (word_valid) begin
                    left_d  = word_in;
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (word_valid) begin
                    state_d = WAIT_L;
                end else if (sel_rise) begin
                    state_d     = WAIT_L;
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d     = IDLE;
            frame_err_d = 1'b0;
        end
    end

    always_comb begin
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        if (!enable) begin
            out_valid_d = 1'b0;
        end else if (pop) begin
            out_left_d  = fifo_rdata[FRAME_W-1:DATA_W];
            out_right_d = fifo_rdata[DATA_W-1:0];
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (push && fifo_full && !pop && (ovf_q != '1)) begin
            ovf_d = ovf_q + CNT_W'(1);
        end
        if (enable && sample_tick && fifo_empty && (unf_q != '1)) begin
            unf_d = unf_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            left_q      <= '0;
            sel_q       <= 1'b1;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= '0;
            unf_q       <= '0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            sel_q       <= sel;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign out_left      = out_left_q;
    assign out_right     = out_right_q;
    assign out_valid     = out_valid_q;
    assign frame_err     = frame_err_q;
    assign overflow_cnt  = ovf_q;
    assign underflow_cnt = unf_q;

endmodule

// File: tb/tb_audio_frame_ctrl.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a frame-level reference model kept in this file.
module tb_audio_frame_ctrl;
    import audio_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          sel;
    logic [DW-1:0] word_in;
    logic          word_valid;
    logic          sample_tick;
    logic [DW-1:0] out_left, out_right;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    fifo_level;
    logic [CW-1:0] overflow_cnt, underflow_cnt;
    logic          frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    stereo_frame_t m_q[$];
    bit            m_active;
    bit            m_have_left;
    logic [DW-1:0] m_left;
    logic [DW-1:0] m_ol, m_or;
    bit            m_ovalid;
    bit            m_ferr;
    int            m_ov, m_un;
    bit            m_sel_prev;

    audio_frame_ctrl #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sel           (sel),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .sample_tick   (sample_tick),
        .out_left      (out_left),
        .out_right     (out_right),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_level    (fifo_level),
        .overflow_cnt  (overflow_cnt),
        .underflow_cnt (underflow_cnt),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 0; m_have_left = 0; m_left = '0;
        m_ol = '0; m_or = '0; m_ovalid = 0; m_ferr = 0;
        m_ov = 0; m_un = 0; m_sel_prev = 1;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_cycle();
        int            size0;
        bit            do_pop;
        stereo_frame_t f;
        if (!enable) begin
            m_active = 0; m_have_left = 0; m_q.delete();
            m_ovalid = 0; m_ferr = 0;
        end else begin
            size0  = m_q.size();
            do_pop = sample_tick && size0 > 0 && (!m_ovalid || out_ready);
            if (do_pop) begin
                f = m_q.pop_front();
                m_ol = f.left; m_or = f.right; m_ovalid = 1;
            end else if (m_ovalid && out_ready) begin
                m_ovalid = 0;
            end
            if (sample_tick && size0 == 0 && m_un < 255) m_un++;
            m_ferr = 0;
            if (!m_active) begin
                m_active = 1;
            end else if (m_have_left) begin
                if (word_valid) begin
                    if (size0 == DEPTH && !do_pop) begin
                        if (m_ov < 255) m_ov++;
                    end else begin
                        f.left = m_left; f.right = word_in;
                        m_q.push_back(f);
                    end
                    m_have_left = 0;
                end else if (sel && !m_sel_prev) begin
                    m_have_left = 0;
                    m_ferr = 1;
                end
            end else if (word_valid) begin
                m_left = word_in;
                m_have_left = 1;
            end
        end
        m_sel_prev = sel;
    endtask

    task automatic check_all();
        check("out_valid", 32'(out_valid), 32'(m_ovalid));
        check("out_left", 32'(out_left), 32'(m_ol));
        check("out_right", 32'(out_right), 32'(m_or));
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("overflow_cnt", 32'(overflow_cnt), 32'(m_ov));
        check("underflow_cnt", 32'(underflow_cnt), 32'(m_un));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
    endtask

    task automatic cycle();
        model_cycle();
        @(posedge clk);
        #1;
        check_all();
        word_valid  = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic put_word(input logic [DW-1:0] w);
        word_in = w; word_valid = 1'b1;
        cycle();
    endtask

    task automatic put_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        put_word(l);
        put_word(r);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cycle();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_out_left_zero", 32'(out_left), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sel = 1'b1; word_in = '0;
        word_valid = 1'b0; sample_tick = 1'b0; out_ready = 1'b1;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        cycle();                       // IDLE -> WAIT_L

        // Basic pairing
        put_pair(16'h1111, 16'h2222);
        check("basic_level", 32'(fifo_level), 32'd1);
        tick();
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_left", 32'(out_left), 32'h1111);
        check("basic_right", 32'(out_right), 32'h2222);
        cycle();
        check("basic_valid_drop", 32'(out_valid), 32'd0);

        // Overflow: five pairs into a four-deep FIFO
        for (int i = 1; i <= 5; i++) put_pair(16'h0100 + 16'(i), 16'h0200 + 16'(i));
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_cnt", 32'(overflow_cnt), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("ovf_order_left", 32'(out_left), 32'(16'h0100 + 16'(i)));
            cycle();
        end
        check("ovf_fifth_absent", 32'(fifo_level), 32'd0);

        // Underflow and saturation
        for (int i = 0; i < 3; i++) tick();
        check("unf_cnt3", 32'(underflow_cnt), 32'd3);
        check("unf_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 260; i++) tick();
        check("unf_sat", 32'(underflow_cnt), 32'd255);

        // Resync on chip-select rise between left and right
        sel = 1'b0;
        cycle();
        put_word(16'hAAAA);
        sel = 1'b1;
        cycle();
        check("resync_err", 32'(frame_err), 32'd1);
        cycle();
        check("resync_err_pulse", 32'(frame_err), 32'd0);
        put_pair(16'h0001, 16'h0002);
        tick();
        check("resync_left", 32'(out_left), 32'h0001);
        check("resync_right", 32'(out_right), 32'h0002);
        cycle();

        // Word coincident with chip-select rise completes the frame
        sel = 1'b0; cycle();
        put_word(16'h0A0A);
        sel = 1'b1;
        put_word(16'h0B0B);
        check("coincide_noerr", 32'(frame_err), 32'd0);
        check("coincide_level", 32'(fifo_level), 32'd1);
        tick(); cycle();

        // Backpressure
        put_pair(16'h5001, 16'h5002);
        put_pair(16'h6001, 16'h6002);
        out_ready = 1'b0;
        tick();
        tick();
        check("bp_level", 32'(fifo_level), 32'd1);
        check("bp_held_left", 32'(out_left), 32'h5001);
        out_ready = 1'b1;
        tick();
        check("bp_second_left", 32'(out_left), 32'h6001);
        cycle();

        // Flush via enable
        put_pair(16'h7001, 16'h7002);
        put_pair(16'h8001, 16'h8002);
        tick();
        enable = 1'b0;
        cycle();
        check("flush_level", 32'(fifo_level), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ovf_kept", 32'(overflow_cnt), 32'd1);
        enable = 1'b1;
        cycle();

        // Reset mid-pair
        put_word(16'h9999);
        do_reset();
        cycle();
        put_pair(16'h3333, 16'h4444);
        tick();
        check("post_rst_left", 32'(out_left), 32'h3333);
        check("post_rst_right", 32'(out_right), 32'h4444);
        cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            enable      = ($urandom_range(99) >= 2);
            if ($urandom_range(99) < 5) sel = ~sel;
            word_valid  = ($urandom_range(99) < 45);
            word_in     = DW'($urandom);
            sample_tick = ($urandom_range(99) < 22);
            out_ready   = ($urandom_range(99) < 70);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
